// File: rtl/icache_responder_if.sv
// Fetch-side and memory-side signals of the icache responder.
// master: fetch/memory agents; slave: the cache.
interface icache_responder_if;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        flush;
  logic [31:0] icache_instr;
  logic        icache_valid;
  logic        icache_error;
  logic        icache_busy;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (
    output icache_req, icache_addr, flush,
    output mem_ack, mem_rdata, mem_err,
    input  icache_instr, icache_valid,
    input  icache_error, icache_busy,
    input  mem_req, mem_addr
  );

  modport slave (
    input  icache_req, icache_addr, flush,
    input  mem_ack, mem_rdata, mem_err,
    output icache_instr, icache_valid,
    output icache_error, icache_busy,
    output mem_req, mem_addr
  );
endinterface

// File: rtl/icache_responder.sv
// Direct-mapped read-only icache, line refill over a
// single-outstanding memory read port.
// Ports: clk, rst (sync, active high), bus (slave):
//   fetch req/addr/flush -> instr/valid/error/busy,
//   mem_req/mem_addr -> mem_ack/mem_rdata/mem_err.
// ICACHE_PERF_CNT_EN adds hit_count/miss_count outputs.
module icache_responder #(
  parameter int unsigned LINES      = 16,
  parameter int unsigned LINE_WORDS = 4,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input logic clk,
  input logic rst,
  icache_responder_if.slave bus
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);
  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;
  localparam int unsigned LO    = 2 + OFF_W;
  localparam int unsigned HI    = LO + IDX_W;

  typedef enum logic [1:0] {
    IDLE, REFILL, RESPOND
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      data_q [LINES][LINE_WORDS];
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LINES-1:0] vld_q;

  logic [TAG_W-1:0] l_tag;
  logic [IDX_W-1:0] l_idx;
  logic [OFF_W-1:0] l_wsel;
  logic [OFF_W-1:0] cnt_q, cnt_n;
  logic             err_q, fpend_q;

  logic [31:0] instr_q, instr_d;
  logic [31:0] maddr_q, maddr_d;
  logic        valid_q, valid_d;
  logic        error_q, error_d;
  logic        busy_q, busy_d;
  logic        mreq_q, mreq_d;

  logic [TAG_W-1:0] a_tag;
  logic [IDX_W-1:0] a_idx;
  logic [OFF_W-1:0] a_wsel;
  logic accept, misal, hit, miss, last;

  assign a_wsel = bus.icache_addr[LO-1:2];
  assign a_idx  = bus.icache_addr[HI-1:LO];
  assign a_tag  = bus.icache_addr[31:HI];

  // busy also covers the response cycle,
  // which is spent in IDLE
  assign accept = bus.icache_req & ~busy_q
                & (state_q == IDLE);
  assign misal  = |bus.icache_addr[1:0];
  // a flush in the request cycle forces a miss
  assign hit    = ~misal & ~bus.flush
                & vld_q[a_idx]
                & (tag_q[a_idx] == a_tag);
  assign miss   = accept & ~misal & ~hit;
  assign last   = cnt_q == OFF_W'(LINE_WORDS - 1);
  assign cnt_n  = cnt_q + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (miss) state_d = REFILL;
      REFILL:
        if (bus.mem_ack & (bus.mem_err | last))
          state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid_d = 1'b0;
    error_d = 1'b0;
    instr_d = '0;
    busy_d  = 1'b0;
    mreq_d  = 1'b0;
    maddr_d = maddr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (1'b1)
            misal: begin
              valid_d = 1'b1;
              error_d = 1'b1;
            end
            hit: begin
              valid_d = 1'b1;
              instr_d = data_q[a_idx][a_wsel];
            end
            default: begin
              busy_d  = 1'b1;
              mreq_d  = 1'b1;
              maddr_d = {a_tag, a_idx,
                         {OFF_W{1'b0}}, 2'b00};
            end
          endcase
        end
      end
      REFILL: begin
        busy_d = 1'b1;
        mreq_d = 1'b1;
        if (bus.mem_ack) begin
          if (bus.mem_err | last)
            mreq_d = 1'b0;
          else
            maddr_d = {l_tag, l_idx, cnt_n, 2'b00};
        end
      end
      RESPOND: begin
        busy_d  = 1'b1;
        valid_d = 1'b1;
        error_d = err_q;
        if (!err_q)
          instr_d = data_q[l_idx][l_wsel];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
      mreq_q  <= 1'b0;
      maddr_q <= RESET_PC;
    end else begin
      instr_q <= instr_d;
      valid_q <= valid_d;
      error_q <= error_d;
      busy_q  <= busy_d;
      mreq_q  <= mreq_d;
      maddr_q <= maddr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      fpend_q <= 1'b0;
      l_tag   <= '0;
      l_idx   <= '0;
      l_wsel  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (miss) begin
            l_tag        <= a_tag;
            l_idx        <= a_idx;
            l_wsel       <= a_wsel;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            fpend_q      <= 1'b0;
            vld_q[a_idx] <= 1'b0;
          end
        end
        REFILL: begin
          if (bus.flush) fpend_q <= 1'b1;
          if (bus.mem_ack) begin
            if (bus.mem_err) err_q <= 1'b1;
            else             cnt_q <= cnt_n;
          end
        end
        RESPOND: begin
          if (!err_q && !fpend_q && !bus.flush) begin
            vld_q[l_idx] <= 1'b1;
            tag_q[l_idx] <= l_tag;
          end
        end
        default: ;
      endcase
      if (bus.flush) vld_q <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state_q == REFILL
        && bus.mem_ack && !bus.mem_err)
      data_q[l_idx][cnt_q] <= bus.mem_rdata;
  end

`ifdef ICACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (accept & ~misal) begin
      if (hit) hit_count  <= hit_count + 32'd1;
      else     miss_count <= miss_count + 32'd1;
    end
  end
`endif

  assign bus.icache_instr = instr_q;
  assign bus.icache_valid = valid_q;
  assign bus.icache_error = error_q;
  assign bus.icache_busy  = busy_q;
  assign bus.mem_req      = mreq_q;
  assign bus.mem_addr     = maddr_q;
endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: directed scenarios plus
// random fetches against an address-level cache model.
module tb_icache_responder;
  localparam int LW = 4;
  localparam int NL = 16;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_responder_if bus();
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_count, miss_count;
`endif

  icache_responder #(
    .LINES(NL), .LINE_WORDS(LW), .RESET_PC(RPC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_count(hit_count),
    .miss_count(miss_count)
`endif
  );

  int errors = 0;
  int checks = 0;
  bit mvalid [NL];
  int unsigned mtag [NL];
  int unsigned mhits = 0;
  int unsigned mmiss = 0;
  int last_lat = 0;

  function automatic logic [31:0] memval(
    input logic [31:0] a);
    if (a >= 32'h100 && a < 32'h110)
      return 32'hA0 + (a - 32'h100) / 4;
    return a * 32'h9E37_79B1 + 32'h1234_5678;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic drop_all();
    for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
  endtask

  task automatic flush_only();
    @(negedge clk);
    bus.flush = 1'b1;
    drop_all();
    @(negedge clk);
    bus.flush = 1'b0;
  endtask

  // One fetch, from request to settled idle.
  task automatic fetch(input logic [31:0] addr,
                       input bit fl,
                       input int err_at,
                       input int flush_at,
                       input int rst_at,
                       input int waits);
    int idx, w, acks, cyc, wl;
    int unsigned tag;
    bit hit, misal, ab, fl_seen;
    logic [31:0] base;
    idx   = int'((addr / (4 * LW)) % NL);
    tag   = addr / (4 * LW * NL);
    misal = (addr % 4) != 0;
    base  = addr - (addr % (4 * LW));
    @(negedge clk);
    bus.icache_req  = 1'b1;
    bus.icache_addr = addr;
    bus.flush       = fl;
    if (fl) drop_all();
    hit = !misal && mvalid[idx] && mtag[idx] == tag;
    @(negedge clk);
    bus.icache_req = 1'b0;
    bus.flush      = 1'b0;
    if (misal) begin
      chk("mis_valid", bus.icache_valid, 1);
      chk("mis_error", bus.icache_error, 1);
      chk("mis_instr", bus.icache_instr, 0);
      chk("mis_memreq", bus.mem_req, 0);
      return;
    end
    if (hit) begin
      mhits++;
      chk("hit_valid", bus.icache_valid, 1);
      chk("hit_error", bus.icache_error, 0);
      chk("hit_instr", bus.icache_instr, memval(addr));
      chk("hit_memreq", bus.mem_req, 0);
      return;
    end
    mmiss++;
    mvalid[idx] = 1'b0;
    cyc = 1; w = 0; acks = 0; ab = 0; fl_seen = 0;
    wl = $urandom_range(0, waits);
    while (w < LW && !ab) begin
      if (rst_at >= 0 && acks == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drop_all();
        mhits = 0;
        mmiss = 0;
        chk("rst_memreq", bus.mem_req, 0);
        chk("rst_busy", bus.icache_busy, 0);
        chk("rst_valid", bus.icache_valid, 0);
        chk("rst_maddr", bus.mem_addr, RPC);
        return;
      end
      chk("rf_busy", bus.icache_busy, 1);
      chk("rf_memreq", bus.mem_req, 1);
      chk("rf_maddr", bus.mem_addr, base + 4 * w);
      chk("rf_valid", bus.icache_valid, 0);
      if (wl > 0) begin
        bus.mem_ack = 1'b0;
        wl--;
      end else begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = memval(base + 4 * w);
        bus.mem_err   = (w == err_at);
      end
      if (w == flush_at && !fl_seen) begin
        bus.flush = 1'b1;
        fl_seen   = 1;
        drop_all();
      end
      @(negedge clk);
      cyc++;
      if (bus.mem_ack) begin
        acks++;
        if (bus.mem_err) ab = 1;
        else begin
          w++;
          wl = $urandom_range(0, waits);
        end
      end
      bus.mem_ack = 1'b0;
      bus.mem_err = 1'b0;
      bus.flush   = 1'b0;
    end
    chk("post_memreq", bus.mem_req, 0);
    chk("post_busy", bus.icache_busy, 1);
    chk("post_valid", bus.icache_valid, 0);
    @(negedge clk);
    cyc++;
    last_lat = cyc;
    chk("rsp_valid", bus.icache_valid, 1);
    chk("rsp_error", bus.icache_error, 32'(ab));
    chk("rsp_instr", bus.icache_instr,
        ab ? 32'h0 : memval(addr));
    chk("rsp_busy", bus.icache_busy, 1);
    if (!ab && !fl_seen) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = tag;
    end
    @(negedge clk);
    chk("idle_busy", bus.icache_busy, 0);
    chk("idle_valid", bus.icache_valid, 0);
  endtask

  initial begin
    logic [31:0] a;
    int e, f;
    rst             = 1'b1;
    bus.icache_req  = 1'b0;
    bus.icache_addr = '0;
    bus.flush       = 1'b0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = '0;
    bus.mem_err     = 1'b0;
    drop_all();
    repeat (2) @(negedge clk);
    chk("reset_instr", bus.icache_instr, 0);
    chk("reset_valid", bus.icache_valid, 0);
    chk("reset_error", bus.icache_error, 0);
    chk("reset_busy", bus.icache_busy, 0);
    chk("reset_memreq", bus.mem_req, 0);
    chk("reset_maddr", bus.mem_addr, RPC);
    rst = 1'b0;

    fetch(32'h100, 0, -1, -1, -1, 0);
    chk("cold_latency", 32'(last_lat), LW + 2);
    fetch(32'h108, 0, -1, -1, -1, 0);

    @(negedge clk);
    bus.icache_req  = 1'b1;
    bus.icache_addr = 32'h104;
    @(negedge clk);
    chk("b2b_v0", bus.icache_valid, 1);
    chk("b2b_i0", bus.icache_instr, 32'hA1);
    bus.icache_addr = 32'h10C;
    @(negedge clk);
    chk("b2b_v1", bus.icache_valid, 1);
    chk("b2b_i1", bus.icache_instr, 32'hA3);
    chk("b2b_memreq", bus.mem_req, 0);
    bus.icache_req = 1'b0;
    mhits += 2;
    @(negedge clk);
    chk("b2b_end", bus.icache_valid, 0);

    fetch(32'h200, 0, -1, -1, -1, 1);
    fetch(32'h100, 0, -1, -1, -1, 0);
    fetch(32'h100, 0, -1, -1, -1, 0);
    fetch(32'h102, 0, -1, -1, -1, 0);
    fetch(32'h300, 0, 1, -1, -1, 0);
    fetch(32'h300, 0, -1, -1, -1, 0);
    fetch(32'h300, 0, -1, -1, -1, 0);
    flush_only();
    fetch(32'h100, 0, -1, -1, -1, 0);
    fetch(32'h100, 1, -1, -1, -1, 0);
    fetch(32'h100, 0, -1, -1, -1, 0);
    fetch(32'h144, 0, -1, 1, -1, 2);
    fetch(32'h144, 0, -1, -1, -1, 0);
    fetch(32'h144, 0, -1, -1, -1, 0);
    fetch(32'h300, 0, -1, -1, 2, 0);
    fetch(32'h300, 0, -1, -1, -1, 0);

    for (int n = 0; n < 150; n++) begin
      a = 32'($urandom_range(0, 511)) * 4;
      if ($urandom_range(0, 15) == 0)
        a = a | 32'($urandom_range(1, 3));
      e = ($urandom_range(0, 11) == 0)
        ? int'($urandom_range(0, LW - 1)) : -1;
      f = ($urandom_range(0, 13) == 0)
        ? int'($urandom_range(0, LW - 1)) : -1;
      fetch(a, ($urandom_range(0, 19) == 0),
            e, f, -1, int'($urandom_range(0, 2)));
    end

`ifdef ICACHE_PERF_CNT_EN
    chk("hit_count", hit_count, mhits);
    chk("miss_count", miss_count, mmiss);
`endif

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end
endmodule
